// File: rtl/datapath_seq_pkg.sv
// Shared types and control-word helpers for the datapath micro-sequencer.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int unsigned CW_NOP = 0;

  localparam logic [4:0] FS_LOAD_REG  = 5'b00000;
  localparam logic [4:0] FS_LOAD_DATA = 5'b11001;
  localparam logic [4:0] FS_ADD       = 5'b00100;
  localparam logic [4:0] FS_INC       = 5'b00010;

  // Control word layout, MSB first: {DA, AA, BA, MB, FS, RW}
  function automatic int unsigned cw_width(int unsigned reg_aw, int unsigned opw);
    return 3 * reg_aw + opw + 2;
  endfunction

  function automatic int unsigned rw_lsb();
    return 0;
  endfunction

  function automatic int unsigned fs_lsb();
    return 1;
  endfunction

  function automatic int unsigned mb_lsb(int unsigned opw);
    return opw + 1;
  endfunction

  function automatic int unsigned ba_lsb(int unsigned opw);
    return opw + 2;
  endfunction

  function automatic int unsigned aa_lsb(int unsigned reg_aw, int unsigned opw);
    return opw + 2 + reg_aw;
  endfunction

  function automatic int unsigned da_lsb(int unsigned reg_aw, int unsigned opw);
    return opw + 2 + 2 * reg_aw;
  endfunction

  function automatic logic [31:0] make_cw(int unsigned reg_aw, int unsigned opw,
                                          int unsigned da, int unsigned aa,
                                          int unsigned ba, int unsigned mb,
                                          int unsigned fs, int unsigned rw);
    logic [31:0] w;
    w = (32'(da) << da_lsb(reg_aw, opw)) | (32'(aa) << aa_lsb(reg_aw, opw)) |
        (32'(ba) << ba_lsb(opw))         | (32'(mb) << mb_lsb(opw))         |
        (32'(fs) << fs_lsb())            | (32'(rw) << rw_lsb());
    return w;
  endfunction

endpackage

// File: rtl/datapath_sequencer_mem.sv
// Program store: one write port, one registered read port that drives cw_out.
module seq_prog_mem #(
  parameter int DEPTH = 8,
  parameter int CW_W  = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [CW_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [CW_W-1:0] rd_data
);

  logic [CW_W-1:0] r_mem [DEPTH];
  logic [CW_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Only the output register resets; a disabled read presents NOP.
  always_ff @(posedge clk) begin
    if (!reset_b)   r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
    else            r_rd_data <= '0;
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer issuing stored control words to Datapath, free-running or single-step.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int OPW    = 5,
  parameter int DEPTH  = 8,
  parameter int CW_W   = 3 * REG_AW + OPW + 2,
  parameter int PC_W   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            wr_en,
  input  logic [CW_W-1:0] wr_data,
  input  logic            clear,
  input  logic            start,
  input  logic            step_mode,
  input  logic            step,
  input  logic            halt_on_z,
  input  logic            z_in,
  output logic [CW_W-1:0] cw_out,
  output logic            cw_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0]   prog_len,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  localparam logic [PC_W:0] LEN_FULL = (PC_W + 1)'(DEPTH);

  seq_state_t      r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, w_pc_nx;
  logic [PC_W:0]   r_prog_len, w_len_nx;
  logic            r_overflow, w_ovf_nx;
  logic            r_cw_valid, r_busy, r_done;
  logic            w_mem_we, w_full, w_last;
  logic [CW_W-1:0] w_rd_data;

  assign w_full = (r_prog_len == LEN_FULL);
  assign w_last = (({1'b0, r_pc} + (PC_W + 1)'(1)) == r_prog_len);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_len_nx   = r_prog_len;
    w_ovf_nx   = r_overflow;
    w_mem_we   = 1'b0;
    if (clear) begin
      w_state_nx = IDLE;
      w_pc_nx    = '0;
      w_len_nx   = '0;
      w_ovf_nx   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && (r_prog_len != '0)) begin
            w_state_nx = RUN;
            w_pc_nx    = '0;
          end else if (wr_en && !start) begin
            if (!w_full) begin
              w_mem_we = 1'b1;
              w_len_nx = r_prog_len + (PC_W + 1)'(1);
            end else begin
              w_ovf_nx = 1'b1;
            end
          end
        end
        RUN: begin
          if (w_last || (halt_on_z && z_in)) begin
            w_state_nx = DONE;
          end else if (step_mode) begin
            w_state_nx = WAIT;
          end else begin
            w_pc_nx = r_pc + PC_W'(1);
          end
        end
        WAIT: begin
          if (step || !step_mode) begin
            w_state_nx = RUN;
            w_pc_nx    = r_pc + PC_W'(1);
          end
        end
        DONE: begin
          if (start) begin
            w_state_nx = RUN;
            w_pc_nx    = '0;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Flags are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_prog_len <= '0;
      r_overflow <= 1'b0;
      r_cw_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_prog_len <= w_len_nx;
      r_overflow <= w_ovf_nx;
      r_cw_valid <= (w_state_nx == RUN);
      r_busy     <= (w_state_nx == RUN) || (w_state_nx == WAIT);
      r_done     <= (w_state_nx == DONE);
    end
  end

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .CW_W  (CW_W),
    .AW    (PC_W)
  ) u_mem (
    .clk     (clk),
    .reset_b (reset_b),
    .wr_en   (w_mem_we & reset_b),
    .wr_addr (r_prog_len[PC_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (w_state_nx == RUN),
    .rd_addr (w_pc_nx),
    .rd_data (w_rd_data)
  );

  assign cw_out   = w_rd_data;
  assign cw_valid = r_cw_valid;
  assign pc       = r_pc;
  assign prog_len = r_prog_len;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench for datapath_sequencer against a program-queue reference model.
module tb_datapath_sequencer;
  import datapath_seq_pkg::*;

  localparam int REG_AW = 3;
  localparam int OPW    = 5;
  localparam int DEPTH  = 8;
  localparam int CW_W   = 16;
  localparam int PC_W   = 3;

  logic            clk = 1'b0;
  logic            reset_b, wr_en, clear, start, step_mode, step, halt_on_z, z_in;
  logic [CW_W-1:0] wr_data;
  logic [CW_W-1:0] cw_out;
  logic            cw_valid, busy, done, overflow;
  logic [PC_W-1:0] pc;
  logic [PC_W:0]   prog_len;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW_W-1:0] prog[$];
  bit              exp_ovf;

  datapath_sequencer #(
    .REG_AW (REG_AW),
    .OPW    (OPW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clear     (clear),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .halt_on_z (halt_on_z),
    .z_in      (z_in),
    .cw_out    (cw_out),
    .cw_valid  (cw_valid),
    .pc        (pc),
    .prog_len  (prog_len),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW_W-1:0] rand_cw();
    logic [4:0] fs_tab [4];
    fs_tab[0] = FS_LOAD_REG;
    fs_tab[1] = FS_LOAD_DATA;
    fs_tab[2] = FS_ADD;
    fs_tab[3] = FS_INC;
    return CW_W'(make_cw(REG_AW, OPW, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 1),
                         32'(fs_tab[$urandom_range(0, 3)]), $urandom_range(0, 1)));
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},  32'(busy), 0);
    check_eq({tag, "_valid"}, 32'(cw_valid), 0);
    check_eq({tag, "_cw"},    32'(cw_out), CW_NOP);
    check_eq({tag, "_done"},  32'(done), 0);
    check_eq({tag, "_pc"},    32'(pc), 0);
    check_eq({tag, "_len"},   32'(prog_len), 32'(prog.size()));
    check_eq({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
  endtask

  task automatic do_write(input logic [CW_W-1:0] w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
    if (prog.size() < DEPTH) prog.push_back(w);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic check_wait(input int i);
    check_eq("wait_valid", 32'(cw_valid), 0);
    check_eq("wait_cw",    32'(cw_out), CW_NOP);
    check_eq("wait_pc",    32'(pc), 32'(i));
    check_eq("wait_busy",  32'(busy), 1);
    check_eq("wait_done",  32'(done), 0);
  endtask

  // Issued sequence is prog[0..last], last cut short by an enabled Z.
  task automatic run_program(input bit sm, input bit hz, input int halt_at, input bit wr_too);
    int len;
    int last;
    len  = prog.size();
    last = (hz && halt_at < len) ? halt_at : len - 1;
    step_mode = sm;
    halt_on_z = hz;
    start = 1'b1;
    wr_en = wr_too;
    wr_data = rand_cw();
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (len == 0) begin
      check_eq("empty_start_busy",  32'(busy), 0);
      check_eq("empty_start_valid", 32'(cw_valid), 0);
      check_eq("empty_start_len",   32'(prog_len), 0);
      return;
    end
    check_eq("start_len", 32'(prog_len), 32'(len));
    for (int i = 0; i <= last; i++) begin
      check_eq("word_valid", 32'(cw_valid), 1);
      check_eq("word_cw",    32'(cw_out), 32'(prog[i]));
      check_eq("word_pc",    32'(pc), 32'(i));
      check_eq("word_busy",  32'(busy), 1);
      check_eq("word_done",  32'(done), 0);
      z_in    = (i == halt_at);
      start   = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = rand_cw();
      tick();
      z_in  = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      if (sm && i != last) begin
        repeat ($urandom_range(0, 2)) begin
          check_wait(i);
          z_in = 1'($urandom);
          tick();
          z_in = 1'b0;
        end
        check_wait(i);
        if ($urandom_range(0, 2) == 0) begin
          step_mode = 1'b0;
          tick();
          step_mode = 1'b1;
        end else begin
          step = 1'b1;
          tick();
          step = 1'b0;
        end
      end
    end
    check_eq("end_done",  32'(done), 1);
    check_eq("end_busy",  32'(busy), 0);
    check_eq("end_valid", 32'(cw_valid), 0);
    check_eq("end_cw",    32'(cw_out), CW_NOP);
    check_eq("end_pc",    32'(pc), 32'(last));
    check_eq("end_len",   32'(prog_len), 32'(len));
    check_eq("end_ovf",   32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    wr_en = 1'b1; wr_data = rand_cw(); clear = 1'b0; start = 1'b0;
    step_mode = 1'b0; step = 1'b0; halt_on_z = 1'b0; z_in = 1'b0;
    reset_b = 1'b0;
    exp_ovf = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    wr_en = 1'b0;
    reset_b = 1'b1;
    tick();

    // Start with an empty program does nothing.
    run_program(1'b0, 1'b0, 99, 1'b0);

    // Three-word free run.
    do_write(16'h2032);
    do_write(16'h4404);
    do_write(16'h6002);
    run_program(1'b0, 1'b0, 99, 1'b0);

    // Write in DONE is ignored.
    do_write(16'hFFFF);
    void'(prog.pop_back());
    check_eq("done_wr_len", 32'(prog_len), 3);

    // Overfilled program: ninth word dropped, overflow sticky.
    do_clear();
    for (int i = 0; i < 9; i++) do_write(rand_cw());
    check_eq("full_len", 32'(prog_len), 8);
    check_eq("full_ovf", 32'(overflow), 1);
    run_program(1'b0, 1'b0, 99, 1'b0);

    // Single step, halt on Z, start+write together.
    do_clear();
    for (int i = 0; i < 3; i++) do_write(rand_cw());
    run_program(1'b1, 1'b0, 99, 1'b0);
    do_clear();
    for (int i = 0; i < 4; i++) do_write(rand_cw());
    run_program(1'b0, 1'b1, 1, 1'b0);
    run_program(1'b0, 1'b0, 99, 1'b1);

    // Clear mid-run, with overflow set beforehand.
    for (int i = 0; i < 6; i++) do_write(rand_cw());
    do_clear();
    for (int i = 0; i < 9; i++) do_write(rand_cw());
    step_mode = 1'b0; halt_on_z = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check_eq("preclr_cw", 32'(cw_out), 32'(prog[1]));
    do_clear();
    check_quiet("clear_run");

    // Reset mid-run.
    for (int i = 0; i < 5; i++) do_write(rand_cw());
    start = 1'b1; tick(); start = 1'b0;
    tick();
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    prog.delete();
    exp_ovf = 1'b0;
    check_quiet("reset_run");

    // Randomized programs and run modes.
    for (int it = 0; it < 40; it++) begin
      if (prog.size() == 0 || $urandom_range(0, 2) != 0) begin
        int n;
        do_clear();
        n = $urandom_range(0, 10);
        for (int k = 0; k < n; k++) do_write(rand_cw());
        check_eq("rand_len", 32'(prog_len), 32'(prog.size()));
        check_eq("rand_ovf", 32'(overflow), 32'(exp_ovf));
      end
      run_program(1'($urandom), 1'($urandom), $urandom_range(0, 9), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
